map_sst_engine: RTL and testbench

- Save-state sequencer: initiator side of the mapper save-state (SST) register port.
- On command, walks mapper registers 0..REG_COUNT-1. SAVE reads each via sst_addr/sst_di into an external byte buffer. LOAD reads the buffer back and writes each register via sst_we_map/sst_dato.
- Sits between the MCU-facing save-state control logic and the active mapper's SST inputs (sst.act, sst.addr, sst.we_map, sst.dato, sst_di).

---
 rtl/map_sst_engine.sv | 146 ++++++++++++++
 tb/tb_map_sst_engine.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/map_sst_engine.sv
// Save-state sequencer: walks mapper registers 0..REG_COUNT-1, dumping them to an
// external byte buffer (SAVE) or restoring them from it (LOAD) over the SST port.
module map_sst_engine #(
    parameter int REG_COUNT = 9,
    parameter int BUF_AW    = 10,
    parameter int BUF_BASE  = 0
) (
    input  logic              clk,
    input  logic              map_rst,
    input  logic              start_save,
    input  logic              start_load,
    output logic              busy,
    output logic              done,
    output logic              sst_act,
    output logic [7:0]        sst_addr,
    output logic              sst_we_map,
    output logic [7:0]        sst_dato,
    input  logic [7:0]        sst_di,
    output logic [BUF_AW-1:0] buf_addr,
    output logic              buf_we,
    output logic [7:0]        buf_di,
    input  logic [7:0]        buf_do
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SAVE  = 3'd2;
    localparam logic [2:0] ST_LOAD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [7:0] LAST_IDX = 8'(REG_COUNT - 1);

    // Buffer address of register slot idx, wrapping modulo 2^BUF_AW.
    function automatic logic [BUF_AW-1:0] buf_offset(input logic [8:0] idx);
        logic [31:0] sum;
        sum = 32'(BUF_BASE) + {23'd0, idx};
        return sum[BUF_AW-1:0];
    endfunction

    logic [2:0]        state_r, state_s;
    logic [7:0]        cnt_r, cnt_s;
    logic              mode_load_r, mode_load_s;
    logic              busy_r, done_r, sst_act_r, sst_we_map_r, buf_we_r;
    logic [7:0]        sst_addr_r, sst_addr_s;
    logic [BUF_AW-1:0] buf_addr_r, buf_addr_s;

    // Next-state and counter sequencing.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        mode_load_s = mode_load_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = 8'd0;
                if (start_save) begin
                    state_s     = ST_SETUP;
                    mode_load_s = 1'b0;
                end else if (start_load) begin
                    state_s     = ST_SETUP;
                    mode_load_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = mode_load_r ? ST_LOAD : ST_SAVE;
                cnt_s   = 8'd0;
            end
            ST_SAVE, ST_LOAD: begin
                if (cnt_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = 8'd0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered and stable
    // for the whole cycle in which the mapper samples them on negedge.
    always_comb begin
        sst_addr_s = 8'd0;
        buf_addr_s = '0;
        case (state_s)
            ST_SETUP: buf_addr_s = buf_offset(9'd0);
            ST_SAVE: begin
                sst_addr_s = cnt_s;
                buf_addr_s = buf_offset({1'b0, cnt_s});
            end
            ST_LOAD: begin
                sst_addr_s = cnt_s;
                buf_addr_s = buf_offset({1'b0, cnt_s} + 9'd1);
            end
            default: begin
                sst_addr_s = 8'd0;
                buf_addr_s = '0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 8'd0;
            mode_load_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            sst_act_r    <= 1'b0;
            sst_we_map_r <= 1'b0;
            buf_we_r     <= 1'b0;
            sst_addr_r   <= 8'd0;
            buf_addr_r   <= '0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            mode_load_r  <= mode_load_s;
            busy_r       <= (state_s != ST_IDLE);
            done_r       <= (state_s == ST_DONE);
            sst_act_r    <= (state_s != ST_IDLE);
            sst_we_map_r <= (state_s == ST_LOAD);
            buf_we_r     <= (state_s == ST_SAVE);
            sst_addr_r   <= sst_addr_s;
            buf_addr_r   <= buf_addr_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign sst_act    = sst_act_r;
    assign sst_we_map = sst_we_map_r;
    assign sst_addr   = sst_addr_r;
    assign buf_addr   = buf_addr_r;
    assign buf_we     = buf_we_r;
    // Data paths forward the other side's already-registered data, gated by state.
    assign buf_di     = (state_r == ST_SAVE) ? sst_di : 8'h00;
    assign sst_dato   = (state_r == ST_LOAD) ? buf_do : 8'h00;

endmodule

// File: tb/tb_map_sst_engine.sv
// Self-checking bench for map_sst_engine: mapper register file and synchronous
// byte buffer models, with expected transfers queued at stimulus time.
module tb_map_sst_engine;

    logic       clk = 1'b0;
    logic       map_rst, start_save, start_load;
    logic       busy, done, sst_act, sst_we_map, buf_we;
    logic [7:0] sst_addr, sst_dato, sst_di, buf_di, buf_do;
    logic [9:0] buf_addr;

    logic       start_save2;
    logic       busy2, done2, sst_act2, sst_we_map2, buf_we2;
    logic [7:0] sst_addr2, sst_dato2, sst_di2, buf_di2;
    logic [9:0] buf_addr2;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0, done_cnt = 0, done_at = 0, done2_cnt = 0;

    logic [7:0]  map_regs [0:255];
    logic [7:0]  orig_regs [0:8];
    logic [7:0]  buf_mem [0:1023];
    logic [17:0] exp_buf_q[$];
    logic [17:0] exp_map_q[$];
    logic [17:0] exp_buf2_q[$];

    always #5 clk = ~clk;

    map_sst_engine #(.REG_COUNT(9), .BUF_AW(10), .BUF_BASE(0)) u_dut (
        .clk(clk), .map_rst(map_rst), .start_save(start_save), .start_load(start_load),
        .busy(busy), .done(done), .sst_act(sst_act), .sst_addr(sst_addr),
        .sst_we_map(sst_we_map), .sst_dato(sst_dato), .sst_di(sst_di),
        .buf_addr(buf_addr), .buf_we(buf_we), .buf_di(buf_di), .buf_do(buf_do)
    );

    map_sst_engine #(.REG_COUNT(9), .BUF_AW(10), .BUF_BASE(1020)) u_dut_wrap (
        .clk(clk), .map_rst(map_rst), .start_save(start_save2), .start_load(1'b0),
        .busy(busy2), .done(done2), .sst_act(sst_act2), .sst_addr(sst_addr2),
        .sst_we_map(sst_we_map2), .sst_dato(sst_dato2), .sst_di(sst_di2),
        .buf_addr(buf_addr2), .buf_we(buf_we2), .buf_di(buf_di2), .buf_do(8'h00)
    );

    assign sst_di  = map_regs[sst_addr];
    assign sst_di2 = map_regs[sst_addr2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Synchronous buffer: one-cycle read latency.
    always @(posedge clk) begin
        if (buf_we) buf_mem[buf_addr] <= buf_di;
        buf_do <= buf_mem[buf_addr];
    end

    // Mapper register file, written on negedge like the real mapper.
    always @(negedge clk) begin
        if (sst_we_map) map_regs[sst_addr] = sst_dato;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_at = busy_cnt;
        end
        if (done2) done2_cnt++;
        if (buf_we) begin
            if (exp_buf_q.size() == 0) chk("buf_we_unexpected", 32'(buf_addr), 32'hFFFF_FFFF);
            else chk("buf_write", 32'({buf_addr, buf_di}), 32'(exp_buf_q.pop_front()));
        end
        if (sst_we_map) begin
            if (exp_map_q.size() == 0) chk("map_we_unexpected", 32'(sst_addr), 32'hFFFF_FFFF);
            else chk("map_write", 32'({2'b00, sst_addr, sst_dato}), 32'(exp_map_q.pop_front()));
        end
        if (buf_we2) begin
            if (exp_buf2_q.size() == 0) chk("wrap_we_unexpected", 32'(buf_addr2), 32'hFFFF_FFFF);
            else chk("wrap_write", 32'({buf_addr2, buf_di2}), 32'(exp_buf2_q.pop_front()));
        end
    end

    task automatic push_save(input int n);
        for (int i = 0; i < n; i++) exp_buf_q.push_back({10'(i), map_regs[i]});
    endtask

    task automatic start_op(input logic s, input logic l);
        busy_cnt   = 0;
        done_cnt   = 0;
        done_at    = 0;
        start_save = s;
        start_load = l;
        @(negedge clk);
        start_save = 1'b0;
        start_load = 1'b0;
        chk("setup_act", 32'(sst_act), 32'd1);
        chk("setup_strobes", 32'({buf_we, sst_we_map}), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 100 && !done; k++) @(negedge clk);
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd11);
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_cycle"}, 32'(done_at), 32'd11);
        chk({tag, "_pending"}, 32'(exp_buf_q.size() + exp_map_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ctrl"}, 32'({busy, done, sst_act, sst_we_map, buf_we}), 32'd0);
        chk({tag, "_sst"}, 32'({sst_addr, sst_dato}), 32'd0);
        chk({tag, "_buf"}, 32'({buf_addr, buf_di}), 32'd0);
    endtask

    initial begin
        map_rst     = 1'b1;
        start_save  = 1'b0;
        start_load  = 1'b0;
        start_save2 = 1'b0;
        for (int i = 0; i < 256; i++) map_regs[i] = 8'h55;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        map_rst = 1'b0;
        @(negedge clk);

        // Save of a known pattern.
        for (int i = 0; i < 8; i++) map_regs[i] = 8'(i);
        map_regs[8] = 8'h0A;
        push_save(9);
        start_op(1'b1, 1'b0);
        wait_done("save");

        // Load: preset buffer via a save, corrupt mapper, load back.
        for (int i = 0; i < 8; i++) map_regs[i] = 8'h1F - 8'(i);
        map_regs[8] = 8'h05;
        for (int i = 0; i < 9; i++) orig_regs[i] = map_regs[i];
        push_save(9);
        start_op(1'b1, 1'b0);
        wait_done("preset");
        for (int i = 0; i < 9; i++) map_regs[i] = 8'hEE;
        for (int i = 0; i < 9; i++) exp_map_q.push_back({2'b00, 8'(i), orig_regs[i]});
        start_op(1'b0, 1'b1);
        wait_done("load");
        for (int i = 0; i < 9; i++) chk("roundtrip_reg", 32'(map_regs[i]), 32'(orig_regs[i]));

        // Simultaneous starts: save wins; a load pulse mid-save is dropped.
        for (int i = 0; i < 9; i++) map_regs[i] = 8'h30 + 8'(i);
        push_save(9);
        start_op(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        wait_done("both_start");
        repeat (3) @(negedge clk);
        chk("no_queued_load", 32'(busy), 32'd0);

        // Reset on the 4th SAVE cycle aborts with no done.
        push_save(4);
        start_op(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        map_rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        map_rst = 1'b0;
        @(negedge clk);
        chk("abort_writes", 32'(exp_buf_q.size()), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        push_save(9);
        start_op(1'b1, 1'b0);
        wait_done("after_abort");

        // Buffer address wrap with BUF_BASE=1020.
        for (int i = 0; i < 9; i++) exp_buf2_q.push_back({10'(1020 + i), map_regs[i]});
        done2_cnt   = 0;
        start_save2 = 1'b1;
        @(negedge clk);
        start_save2 = 1'b0;
        for (int k = 0; k < 100 && !done2; k++) @(negedge clk);
        chk("wrap_done_seen", 32'(done2), 32'd1);
        repeat (2) @(negedge clk);
        chk("wrap_pending", 32'(exp_buf2_q.size()), 32'd0);
        chk("wrap_done_pulses", 32'(done2_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
